// File: rtl/tile_framebuffer_arbiter.sv
// Shares one asynchronous 16-bit SRAM between VGA scan-out reads and clipped tile
// writes from several producers, with double buffering that swaps on vertical sync.
module tile_framebuffer_arbiter #(
   parameter int FB_WIDTH  = 800,
   parameter int FB_HEIGHT = 525,
   parameter int TILE_DIM  = 8,
   parameter int NUM_SRC   = 2,
   parameter int ADDR_W    = 20,
   parameter int SRC_W     = 3
) (
   input  logic              BOARD_CLK,
   input  logic              RESET,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [15:0]       SRAM_DQ_OUT,
   output logic              SRAM_DQ_OE,
   input  logic [15:0]       SRAM_DQ_IN,
   output logic              SRAM_WE_N,
   input  logic [9:0]        VGA_SCAN_X,
   input  logic [9:0]        VGA_SCAN_Y,
   input  logic              VGA_BLANK_N,
   input  logic              VGA_VS,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B,
   output logic              pixel_valid,
   input  logic              tile_req,
   output logic              tile_ready,
   input  logic [SRC_W-1:0]  tile_src,
   input  logic [9:0]        tile_x,
   input  logic [9:0]        tile_y,
   output logic [SRC_W-1:0]  px_src,
   output logic [5:0]        px_x,
   output logic [5:0]        px_y,
   input  logic [15:0]       px_data,
   output logic              tile_done,
   input  logic              swap_req,
   output logic              swap_done,
   output logic              front_buf
);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;
   typedef enum logic {PH_READ = 1'b0, PH_WRITE = 1'b1} phase_e;

   localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_WIDTH * FB_HEIGHT);
   localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(FB_WIDTH);
   localparam logic [5:0]        LAST_PX   = 6'(TILE_DIM - 1);
   localparam logic [10:0]       FB_W11    = 11'(FB_WIDTH);
   localparam logic [10:0]       FB_H11    = 11'(FB_HEIGHT);

   if (NUM_SRC < 1 || NUM_SRC > 8 || NUM_SRC > (1 << SRC_W) || TILE_DIM < 2 || TILE_DIM > 64)
   begin : g_param_check
      $error("tile_framebuffer_arbiter: parameter out of range");
   end

   state_e             state_q, state_d;
   phase_e             phase_q;
   logic               target_q, front_buf_q, swap_pending_q, vs_prev_q, swap_done_q;
   logic [9:0]         ox_q, oy_q;
   logic [5:0]         px_x_q, px_y_q;
   logic [SRC_W-1:0]   px_src_q;
   logic [ADDR_W-1:0]  sram_addr_q;
   logic [15:0]        sram_dq_q;
   logic               sram_we_n_q, sram_oe_q, rd_pend_q, pixel_valid_q, tile_done_q;
   logic [7:0]         vga_r_q, vga_g_q, vga_b_q;

   logic               read_slot, stream_slot, accept, last_px, in_bounds, vs_fall;
   logic [10:0]        abs_x, abs_y;
   logic [ADDR_W-1:0]  scan_addr, wr_addr;

   // Blanking turns every cycle into a write slot and parks the phase at READ.
   assign read_slot   = VGA_BLANK_N && (phase_q == PH_READ);
   assign stream_slot = (state_q == STREAM) && !read_slot;
   assign accept      = tile_req && tile_ready;
   assign last_px     = (px_x_q == LAST_PX) && (px_y_q == LAST_PX);
   assign vs_fall     = vs_prev_q && !VGA_VS;

   // Bounds are compared at 11 bits so an origin near 1023 plus a tile offset cannot wrap.
   assign abs_x     = {1'b0, ox_q} + {5'b0, px_x_q};
   assign abs_y     = {1'b0, oy_q} + {5'b0, px_y_q};
   assign in_bounds = (abs_x < FB_W11) && (abs_y < FB_H11);

   assign scan_addr = ADDR_W'(VGA_SCAN_X) + ADDR_W'(VGA_SCAN_Y) * STRIDE
                    + (front_buf_q ? BUF1_BASE : '0);
   assign wr_addr   = ADDR_W'(abs_x) + ADDR_W'(abs_y) * STRIDE
                    + (target_q ? BUF1_BASE : '0);

   always_ff @(posedge BOARD_CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (tile_req)               state_d = STREAM;
         STREAM:  if (stream_slot && last_px) state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_comb begin
      tile_ready = (state_q == IDLE);
   end

   // NOTE: all sequential state below uses non-blocking assignments only.
   always_ff @(posedge BOARD_CLK) begin
      if (RESET) begin
         phase_q        <= PH_READ;
         target_q       <= 1'b0;
         front_buf_q    <= 1'b0;
         swap_pending_q <= 1'b0;
         vs_prev_q      <= 1'b1;
         swap_done_q    <= 1'b0;
         ox_q           <= '0;
         oy_q           <= '0;
         px_x_q         <= '0;
         px_y_q         <= '0;
         px_src_q       <= '0;
         sram_addr_q    <= '0;
         sram_dq_q      <= '0;
         sram_we_n_q    <= 1'b1;
         sram_oe_q      <= 1'b0;
         rd_pend_q      <= 1'b0;
         pixel_valid_q  <= 1'b0;
         tile_done_q    <= 1'b0;
         vga_r_q        <= '0;
         vga_g_q        <= '0;
         vga_b_q        <= '0;
      end else begin
         phase_q       <= (VGA_BLANK_N && phase_q == PH_READ) ? PH_WRITE : PH_READ;
         rd_pend_q     <= read_slot;
         pixel_valid_q <= rd_pend_q;
         if (rd_pend_q) begin
            vga_r_q <= {SRAM_DQ_IN[4:0],   SRAM_DQ_IN[4:2]};
            vga_g_q <= {SRAM_DQ_IN[10:5],  SRAM_DQ_IN[10:9]};
            vga_b_q <= {SRAM_DQ_IN[15:11], SRAM_DQ_IN[15:13]};
         end

         sram_we_n_q <= 1'b1;
         sram_oe_q   <= 1'b0;
         tile_done_q <= 1'b0;
         if (read_slot) begin
            sram_addr_q <= scan_addr;
         end else if (stream_slot) begin
            if (in_bounds) begin
               sram_addr_q <= wr_addr;
               sram_dq_q   <= px_data;
               sram_we_n_q <= 1'b0;
               sram_oe_q   <= 1'b1;
            end
            if (px_x_q == LAST_PX) begin
               px_x_q <= '0;
               px_y_q <= last_px ? 6'd0 : px_y_q + 6'd1;
            end else begin
               px_x_q <= px_x_q + 6'd1;
            end
            tile_done_q <= last_px;
         end

         if (accept) begin
            ox_q     <= tile_x;
            oy_q     <= tile_y;
            px_src_q <= tile_src;
            target_q <= ~front_buf_q;
            px_x_q   <= '0;
            px_y_q   <= '0;
         end

         vs_prev_q   <= VGA_VS;
         swap_done_q <= 1'b0;
         if (vs_fall && (swap_pending_q || swap_req)) begin
            front_buf_q    <= ~front_buf_q;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b1;
         end else if (swap_req) begin
            swap_pending_q <= 1'b1;
         end
      end
   end

   assign SRAM_ADDR   = sram_addr_q;
   assign SRAM_DQ_OUT = sram_dq_q;
   assign SRAM_DQ_OE  = sram_oe_q;
   assign SRAM_WE_N   = sram_we_n_q;
   assign VGA_R       = vga_r_q;
   assign VGA_G       = vga_g_q;
   assign VGA_B       = vga_b_q;
   assign pixel_valid = pixel_valid_q;
   assign px_src      = px_src_q;
   assign px_x        = px_x_q;
   assign px_y        = px_y_q;
   assign tile_done   = tile_done_q;
   assign swap_done   = swap_done_q;
   assign front_buf   = front_buf_q;

endmodule

// File: doc/tile_framebuffer_arbiter.md
Name: tile_framebuffer_arbiter

Overview:
Parametrised successor to the single-frame tile writer. Arbitrates one asynchronous 16-bit SRAM between VGA scan-out reads and tile writes from NUM_SRC tile producers. Double buffering uses an explicit swap request applied at vertical sync. Tile pixels outside the frame are clipped. Sits between the tile renderers and the top-level SRAM/VGA pins; the DQ tristate lives at top level.

Parameters:
FB_WIDTH, 800, frame width in pixels (also the row stride)
FB_HEIGHT, 525, frame height in rows; buffer 1 base = FB_WIDTH*FB_HEIGHT
TILE_DIM, 8, tile edge in pixels (2..64)
NUM_SRC, 2, number of tile producers (1..8)
ADDR_W, 20, SRAM address width
SRC_W, 3, width of tile_src (at least clog2(NUM_SRC), minimum 1)

Ports:
BOARD_CLK  in  1  50 MHz system clock; all logic is on the rising edge
RESET  in  1  synchronous, active-high reset
SRAM_ADDR  out  ADDR_W  registered SRAM address
SRAM_DQ_OUT  out  16  registered write data
SRAM_DQ_OE  out  1  high means top level drives DQ
SRAM_DQ_IN  in  16  SRAM read data
SRAM_WE_N  out  1  registered active-low write enable
VGA_SCAN_X, VGA_SCAN_Y  in  10 each  current scan coordinate
VGA_BLANK_N  in  1  high during active video
VGA_VS  in  1  vertical sync, active low
VGA_R, VGA_G, VGA_B  out  8 each  expanded pixel colour
pixel_valid  out  1  one-cycle pulse when VGA_R/G/B are updated
tile_req  in  1  tile write request (valid)
tile_ready  out  1  high when IDLE; a request is accepted when tile_req && tile_ready
tile_src  in  SRC_W  producer index for the request
tile_x, tile_y  in  10 each  tile origin in the frame
px_src  out  SRC_W  latched producer index for the current fetch
px_x, px_y  out  6 each  current tile-local pixel
px_data  in  16  RGB565 pixel from producer px_src at (px_x, px_y); combinational, same cycle
tile_done  out  1  one-cycle pulse after the tile's last slot
swap_req  in  1  pulse requesting a buffer swap
swap_done  out  1  one-cycle pulse when front_buf toggles
front_buf  out  1  buffer currently being displayed

Behaviour:
- Reset values: SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, VGA_R/G/B=0, pixel_valid=0, tile_done=0, swap_done=0, front_buf=0, px_x=px_y=0, px_src=0, state IDLE, slot phase READ, swap_pending=0.
- Reset asserted mid-stream aborts the tile: no tile_done is issued and SRAM_WE_N=1 on the next edge.
- Slot schedule:
  - While VGA_BLANK_N=1, cycles alternate READ and WRITE, starting with READ.
  - While VGA_BLANK_N=0, every cycle is a WRITE slot and the phase is held at READ.
- READ slot:
  - SRAM_ADDR <= SCAN_X + SCAN_Y*FB_WIDTH + (front_buf ? FB_WIDTH*FB_HEIGHT : 0).
  - SRAM_WE_N <= 1, SRAM_DQ_OE <= 0.
  - On the next edge, capture SRAM_DQ_IN: R = {d[4:0], d[4:2]}, G = {d[10:5], d[10:9]}, B = {d[15:11], d[15:13]}.
  - pixel_valid pulses with that capture.
  - Latency from scan-input sample to colour output: 2 cycles.
- FSM IDLE:
  - tile_ready=1.
  - On accept, latch tile_x, tile_y and tile_src, latch target buffer = ~front_buf, clear px_x/px_y, and go to STREAM.
- FSM STREAM:
  - tile_ready=0.
  - Each WRITE slot handles pixel (px_x, px_y), then advances px_x; at TILE_DIM-1, px_x wraps to 0 and px_y increments.
  - In-bounds pixel (ox+px_x < FB_WIDTH and oy+px_y < FB_HEIGHT): SRAM_ADDR <= (ox+px_x) + (oy+px_y)*FB_WIDTH + target-buffer base; SRAM_DQ_OUT <= px_data; SRAM_WE_N <= 0; SRAM_DQ_OE <= 1.
  - Out-of-bounds pixel: the slot is consumed, SRAM_WE_N stays 1 and the pixel is not written.
  - A READ slot during STREAM does not advance the pointer.
  - After the slot for (TILE_DIM-1, TILE_DIM-1): tile_done=1 for one cycle, state returns to IDLE, and tile_ready rises the following cycle.
  - A non-write cycle always has SRAM_WE_N=1 and SRAM_DQ_OE=0.
- Arithmetic:
  - Address computed at ADDR_W width, no truncation below ADDR_W.
  - Bounds compare done at 11 bits so that 1023+63 does not wrap.
- Buffer swap:
  - swap_req sets swap_pending; repeat requests while pending are absorbed.
  - Falling edge of VGA_VS (registered prev=1, now=0) with swap_pending: front_buf toggles, swap_pending clears, swap_done pulses.
  - Simultaneous swap_req and VS falling edge: that edge swaps.
  - A tile in flight keeps its latched target buffer across a swap.

Test Plan:
- Reset, VGA_BLANK_N=0, tile_req with src=1, origin (16,2), TILE_DIM=8, px_data=0x1234 -> exactly 64 SRAM_WE_N=0 cycles; first address 16+1600+420000=421616; tile_done pulses once; tile_ready returns to 1.
- VGA_BLANK_N=1, scan (10,1), SRAM_DQ_IN=0xFFFF, front_buf=0 -> READ address 810; VGA_R/G/B=0xFF/0xFF/0xFF with pixel_valid 2 cycles later; writes occur only on alternating cycles.
- Tile at (796,523) -> only 4x2=8 writes; the other 56 slots keep SRAM_WE_N=1; tile_done still pulses.
- swap_req pulse, then VGA_VS 1->0 -> front_buf=1 and swap_done pulse on that edge; the next READ address is offset by 420000; a tile accepted before the swap still writes to buffer 1.
- RESET asserted at pixel 30 of a tile -> next cycle SRAM_WE_N=1, tile_ready=1, no tile_done; a new request then streams from (0,0).
- NUM_SRC=4 with the request on src 3 -> px_src=3 for every slot of that tile.
